// File: rtl/mem_req_arbiter_if.sv
// Request/response/memory-command bundle between two requesters, the arbiter
// and the single-port memory controller datapath.
interface mem_req_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                  m0_req_valid;
  logic                  m0_req_ready;
  logic                  m0_req_wr;
  logic [ADDR_WIDTH-1:0] m0_req_addr;
  logic [DATA_WIDTH-1:0] m0_req_wdata;
  logic                  m0_rsp_valid;
  logic [DATA_WIDTH-1:0] m0_rsp_data;

  logic                  m1_req_valid;
  logic                  m1_req_ready;
  logic                  m1_req_wr;
  logic [ADDR_WIDTH-1:0] m1_req_addr;
  logic [DATA_WIDTH-1:0] m1_req_wdata;
  logic                  m1_rsp_valid;
  logic [DATA_WIDTH-1:0] m1_rsp_data;

  logic                  mem_valid;
  logic                  mem_rd_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  // Arbiter side
  modport slave (
    input  m0_req_valid, m0_req_wr, m0_req_addr, m0_req_wdata,
    output m0_req_ready, m0_rsp_valid, m0_rsp_data,
    input  m1_req_valid, m1_req_wr, m1_req_addr, m1_req_wdata,
    output m1_req_ready, m1_rsp_valid, m1_rsp_data,
    output mem_valid, mem_rd_wr, mem_addr, mem_wr_data,
    input  mem_rd_data
  );

  // Requester/memory environment side
  modport master (
    output m0_req_valid, m0_req_wr, m0_req_addr, m0_req_wdata,
    input  m0_req_ready, m0_rsp_valid, m0_rsp_data,
    output m1_req_valid, m1_req_wr, m1_req_addr, m1_req_wdata,
    input  m1_req_ready, m1_rsp_valid, m1_rsp_data,
    input  mem_valid, mem_rd_wr, mem_addr, mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Two-requester round-robin arbiter: issues one registered memory command per
// accepted request and routes the single outstanding read back to its owner.
module mem_req_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic           clk,
  input  logic           rst,
  mem_req_arbiter_if.slave bus
);

  localparam logic [3:0] CNT_INIT = 4'(RD_LATENCY);

  typedef enum logic {IDLE, WAIT_RD} state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q;
  logic                  owner_q;
  logic [3:0]            cnt_q;

  logic                  gnt0, gnt1, acc;
  logic                  acc_wr;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  rd_done;

  logic                  vld_p1, wr_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [DATA_WIDTH-1:0] wdata_p1;
  logic                  rsp0_vld_p1, rsp1_vld_p1;
  logic [DATA_WIDTH-1:0] rsp0_data_p1, rsp1_data_p1;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc && !acc_wr) state_d = WAIT_RD;
      WAIT_RD: if (rd_done)        state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // Grant goes to the sole requester, or on contention to the one not served last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE) begin
      gnt0 = bus.m0_req_valid && (!bus.m1_req_valid ||  last_grant_q);
      gnt1 = bus.m1_req_valid && (!bus.m0_req_valid || !last_grant_q);
    end
  end

  assign bus.m0_req_ready = gnt0;
  assign bus.m1_req_ready = gnt1;
  assign acc       = gnt0 | gnt1;
  assign acc_wr    = gnt1 ? bus.m1_req_wr    : bus.m0_req_wr;
  assign acc_addr  = gnt1 ? bus.m1_req_addr  : bus.m0_req_addr;
  assign acc_wdata = gnt1 ? bus.m1_req_wdata : bus.m0_req_wdata;
  assign rd_done   = (state_q == WAIT_RD) && (cnt_q == 4'd0);

  // Stage p0 -> p1: accepted request becomes the memory command; read data becomes the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= 4'd0;
      vld_p1       <= 1'b0;
      wr_p1        <= 1'b0;
      addr_p1      <= '0;
      wdata_p1     <= '0;
      rsp0_vld_p1  <= 1'b0;
      rsp1_vld_p1  <= 1'b0;
      rsp0_data_p1 <= '0;
      rsp1_data_p1 <= '0;
    end else begin
      vld_p1      <= acc;
      rsp0_vld_p1 <= rd_done && !owner_q;
      rsp1_vld_p1 <= rd_done &&  owner_q;
      if (acc) begin
        last_grant_q <= gnt1;
        wr_p1        <= acc_wr;
        addr_p1      <= acc_addr;
        wdata_p1     <= acc_wdata;
        if (!acc_wr) begin
          owner_q <= gnt1;
          cnt_q   <= CNT_INIT;
        end
      end else if (state_q == WAIT_RD && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (rd_done) begin
        if (owner_q) rsp1_data_p1 <= bus.mem_rd_data;
        else         rsp0_data_p1 <= bus.mem_rd_data;
      end
    end
  end

  assign bus.mem_valid    = vld_p1;
  assign bus.mem_rd_wr    = wr_p1;
  assign bus.mem_addr     = addr_p1;
  assign bus.mem_wr_data  = wdata_p1;
  assign bus.m0_rsp_valid = rsp0_vld_p1;
  assign bus.m0_rsp_data  = rsp0_data_p1;
  assign bus.m1_rsp_valid = rsp1_vld_p1;
  assign bus.m1_rsp_data  = rsp1_data_p1;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios plus random traffic, checked every
// cycle against a cycle-indexed transaction model and a behavioural memory.
module tb_mem_req_arbiter;
  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int RDL = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_req_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  mem_req_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RDL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: absolute cycle numbers for when the arbiter is free and when a response lands.
  int         cyc = 0;
  int         busy_until = 0;
  int         rsp_at = -1;
  bit         last = 1'b1;
  bit         rsp_own;
  logic [DW-1:0] rsp_val;
  bit         armed = 1'b0;

  logic          e_mv, e_wr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic          e_rv [2];
  logic [DW-1:0] e_rd [2];

  bit            p_v [2];
  bit            p_wr [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_wdata [2];

  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] hw_mem  [int];
  logic [DW-1:0] rd_pipe [int];

  function automatic logic [DW-1:0] init_val(input int a);
    return 32'hC0DE_0000 ^ (a * 32'h0000_9E37);
  endfunction

  function automatic logic [DW-1:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [DW-1:0] hw_rd(input int a);
    return hw_mem.exists(a) ? hw_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic apply();
    bus.m0_req_valid = p_v[0];
    bus.m0_req_wr    = p_wr[0];
    bus.m0_req_addr  = p_addr[0];
    bus.m0_req_wdata = p_wdata[0];
    bus.m1_req_valid = p_v[1];
    bus.m1_req_wr    = p_wr[1];
    bus.m1_req_addr  = p_addr[1];
    bus.m1_req_wdata = p_wdata[1];
  endtask

  // One clock cycle: drive, check the cycle's outputs, advance the model across the edge.
  task automatic tick(input bit r);
    bit er0, er1, a0, a1, w;
    rst = r;
    if (rd_pipe.exists(cyc)) begin
      bus.mem_rd_data = rd_pipe[cyc];
      rd_pipe.delete(cyc);
    end else begin
      bus.mem_rd_data = $urandom;
    end
    apply();
    #1;
    er0 = (cyc >= busy_until) && p_v[0] && (!p_v[1] || last == 1'b1);
    er1 = (cyc >= busy_until) && p_v[1] && (!p_v[0] || last == 1'b0);
    if (armed) begin
      chk("m0_req_ready", bus.m0_req_ready, er0);
      chk("m1_req_ready", bus.m1_req_ready, er1);
      chk("mem_valid",    bus.mem_valid,    e_mv);
      chk("mem_rd_wr",    bus.mem_rd_wr,    e_wr);
      chk("mem_addr",     bus.mem_addr,     e_addr);
      chk("mem_wr_data",  bus.mem_wr_data,  e_wdata);
      chk("m0_rsp_valid", bus.m0_rsp_valid, e_rv[0]);
      chk("m0_rsp_data",  bus.m0_rsp_data,  e_rd[0]);
      chk("m1_rsp_valid", bus.m1_rsp_valid, e_rv[1]);
      chk("m1_rsp_data",  bus.m1_rsp_data,  e_rd[1]);
    end
    if (bus.mem_valid === 1'b1) begin
      if (bus.mem_rd_wr) hw_mem[int'(bus.mem_addr)] = bus.mem_wr_data;
      else               rd_pipe[cyc + RDL] = hw_rd(int'(bus.mem_addr));
    end
    a0 = er0 && !r;
    a1 = er1 && !r;
    if (r) begin
      last = 1'b1; busy_until = 0; rsp_at = -1;
      e_mv = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0;
      e_rv[0] = 1'b0; e_rv[1] = 1'b0; e_rd[0] = '0; e_rd[1] = '0;
    end else begin
      e_rv[0] = 1'b0;
      e_rv[1] = 1'b0;
      if (rsp_at == cyc + 1) begin
        e_rv[rsp_own] = 1'b1;
        e_rd[rsp_own] = rsp_val;
      end
      e_mv = a0 | a1;
      if (a0 | a1) begin
        w       = a1;
        e_wr    = p_wr[w];
        e_addr  = p_addr[w];
        e_wdata = p_wdata[w];
        last    = w;
        if (p_wr[w]) begin
          ref_mem[int'(p_addr[w])] = p_wdata[w];
        end else begin
          rsp_at     = cyc + 2 + RDL;
          busy_until = rsp_at;
          rsp_own    = w;
          rsp_val    = ref_rd(int'(p_addr[w]));
        end
        p_v[w] = 1'b0;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic gen(input int pct_new);
    for (int i = 0; i < 2; i++) begin
      if (p_v[i] && $urandom_range(31) == 0) begin
        p_v[i] = 1'b0;
      end else if (!p_v[i] && $urandom_range(99) < pct_new) begin
        p_v[i]     = 1'b1;
        p_wr[i]    = 1'($urandom_range(1));
        p_addr[i]  = AW'($urandom_range(7));
        p_wdata[i] = $urandom;
      end
    end
  endtask

  task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p_v[i] = 1'b1; p_wr[i] = wr; p_addr[i] = a; p_wdata[i] = d;
  endtask

  initial begin
    bit seen;
    int j;
    for (int i = 0; i < 2; i++) begin
      p_v[i] = 1'b0; p_wr[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0;
    end
    bus.mem_rd_data = '0;

    // Reset for two cycles with no requests, then idle
    tick(1'b1);
    armed = 1'b1;
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);

    // Single write from m0
    set_req(0, 1'b1, 16'h0010, 32'hDEAD_BEEF);
    tick(1'b0);
    chk("wr_cmd_valid", bus.mem_valid,   1'b1);
    chk("wr_cmd_rdwr",  bus.mem_rd_wr,   1'b1);
    chk("wr_cmd_addr",  bus.mem_addr,    16'h0010);
    chk("wr_cmd_data",  bus.mem_wr_data, 32'hDEAD_BEEF);
    tick(1'b0);
    chk("wr_cmd_pulse", bus.mem_valid,   1'b0);

    // Single read from m1, four cycles accept-to-response
    ref_mem[32'h20] = 32'h1234_5678;
    hw_mem[32'h20]  = 32'h1234_5678;
    set_req(1, 1'b0, 16'h0020, 32'h0);
    tick(1'b0);
    for (int k = 0; k < 3; k++) tick(1'b0);
    chk("rd_rsp_valid",  bus.m1_rsp_valid, 1'b1);
    chk("rd_rsp_data",   bus.m1_rsp_data,  32'h1234_5678);
    chk("rd_other_idle", bus.m0_rsp_valid, 1'b0);
    tick(1'b0);

    // Contention: both hold writes, grants alternate starting with m0
    for (int k = 0; k < 6; k++) begin
      if (!p_v[0]) set_req(0, 1'b1, AW'(16'h0100 + k), $urandom);
      if (!p_v[1]) set_req(1, 1'b1, AW'(16'h0200 + k), $urandom);
      tick(1'b0);
      chk("rr_order", {24'h0, bus.mem_addr[15:8]}, (k % 2 == 0) ? 32'h1 : 32'h2);
    end
    p_v[0] = 1'b0; p_v[1] = 1'b0;
    tick(1'b0);

    // Read blocks a pending write until the response cycle
    set_req(0, 1'b0, 16'h0003, 32'h0);
    tick(1'b0);
    set_req(1, 1'b1, 16'h0300, 32'hA5A5_0300);
    j = 0;
    while (j < 10) begin
      tick(1'b0);
      if (!p_v[1]) break;
      j++;
    end
    chk("blk_accept_at", j, RDL + 1);
    chk("blk_wr_cmd",    bus.mem_valid, 1'b1);
    chk("blk_wr_addr",   bus.mem_addr,  16'h0300);
    tick(1'b0);

    // Reset one cycle after a read command discards the read
    set_req(1, 1'b0, 16'h0005, 32'h0);
    tick(1'b0);
    tick(1'b0);
    tick(1'b1);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      seen |= (bus.m0_rsp_valid === 1'b1) || (bus.m1_rsp_valid === 1'b1);
      tick(1'b0);
    end
    chk("rst_no_rsp", seen, 1'b0);
    set_req(1, 1'b0, 16'h0006, 32'h0);
    tick(1'b0);
    for (int k = 0; k < 3; k++) tick(1'b0);
    chk("post_rst_rsp_valid", bus.m1_rsp_valid, 1'b1);
    chk("post_rst_rsp_data",  bus.m1_rsp_data,  ref_rd(6));
    tick(1'b0);

    // Random traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      gen(35);
      tick($urandom_range(399) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port memory controller datapath.
- Accepts read/write requests on per-requester valid/ready handshakes and issues one registered command per accepted request on the memory port.
- Tracks the single outstanding read and returns its data, with a one-cycle response strobe, to the requester that issued it.

Parameters:
- DATA_WIDTH, 32, width of write/read data.
- ADDR_WIDTH, 16, width of memory address.
- RD_LATENCY, 2, cycles from mem_valid (read) to mem_rd_data valid. Legal range 1..15.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- m0_req_valid  input  1  requester 0 request present.
- m0_req_ready  output  1  requester 0 request accepted this cycle when valid&ready.
- m0_req_wr  input  1  1=write, 0=read.
- m0_req_addr  input  ADDR_WIDTH  request address.
- m0_req_wdata  input  DATA_WIDTH  write data.
- m0_rsp_valid  output  1  one-cycle read-data strobe for requester 0.
- m0_rsp_data  output  DATA_WIDTH  read data, valid with m0_rsp_valid.
- m1_req_valid, m1_req_ready, m1_req_wr, m1_req_addr, m1_req_wdata, m1_rsp_valid, m1_rsp_data: identical for requester 1.
- mem_valid  output  1  memory command strobe, one cycle per command.
- mem_rd_wr  output  1  1=write, 0=read.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_wr_data  output  DATA_WIDTH  memory write data.
- mem_rd_data  input  DATA_WIDTH  memory read data, valid RD_LATENCY cycles after a read mem_valid.

Behaviour:
- Reset (rst=1 at clock edge), all registered outputs 0:
  - mem_valid, mem_rd_wr, mem_addr, mem_wr_data = 0.
  - m0/m1_rsp_valid, m0/m1_rsp_data = 0.
  - State = IDLE; last_grant = 1, so requester 0 wins the first contention.
  - Reset mid-read discards the read: no rsp_valid is produced.
- FSM states: IDLE, WAIT_RD.
- IDLE:
  - mX_req_ready is combinational from the valids. Only one requester is granted; the other's ready = 0.
  - Only one valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - Accept = valid&ready. On accept, last_grant updates to the accepted requester; otherwise last_grant holds.
  - Accept at edge T: mem_valid=1 during cycle T+1 with mem_rd_wr/mem_addr/mem_wr_data registered from the accepted request. mem_valid is a one-cycle pulse unless another accept follows.
  - Write accept: remain in IDLE. Back-to-back writes are accepted every cycle (throughput 1/cycle).
  - Read accept: go to WAIT_RD, store owner ID, load down-counter.
- WAIT_RD:
  - Both req_ready = 0; no accepts.
  - Counter spans RD_LATENCY cycles after the read mem_valid cycle.
  - At the edge ending cycle T+1+RD_LATENCY: capture mem_rd_data into owner's rsp_data, pulse owner's rsp_valid in cycle T+2+RD_LATENCY, return to IDLE.
  - Next accept is possible in cycle T+2+RD_LATENCY.
  - Total read latency, accept edge to rsp_valid: RD_LATENCY+2 cycles.
- Response outputs:
  - rsp_data holds its last value until the next response to that requester.
  - The non-owner's rsp_valid stays 0.
- Requester contract: hold valid, wr, addr, wdata stable until accepted. The arbiter never drops an accepted request.
- mem_wr_data is don't-care for reads but is still registered from req_wdata.
- A requester deasserting valid before acceptance causes no memory command.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, no valids -> all outputs 0, req_ready=0, mem_valid never asserted.
- Single write: m0 write addr=0x0010 data=0xDEADBEEF -> m0_req_ready=1 in the same cycle; next cycle mem_valid=1, mem_rd_wr=1, mem_addr=0x0010, mem_wr_data=0xDEADBEEF; one cycle only.
- Single read, RD_LATENCY=2: m1 read addr=0x0020, model returns 0x12345678 two cycles after mem_valid -> m1_rsp_valid=1 with m1_rsp_data=0x12345678 exactly 4 cycles after the accept edge; m0_rsp_valid stays 0; req_ready=0 throughout WAIT_RD.
- Contention round-robin: m0 and m1 both hold write requests continuously -> accept order m0, m1, m0, m1 on consecutive cycles; mem_addr alternates accordingly.
- Read blocks arbitration: m0 read accepted while m1 write pending -> m1_req_ready=0 until m0_rsp_valid cycle; m1 accepted in that cycle; m1 write mem_valid follows one cycle later.
- Reset mid-read: assert rst one cycle after a read mem_valid -> no rsp_valid ever, state IDLE; a fresh m1 read afterwards completes with correct data and latency.
